// File: rtl/mmio_test_responder_pkg.sv
// Register offsets, status-word layout and a status packing helper shared by the
// MMIO test responder and its console FIFO.
package mmio_test_responder_pkg;

    typedef enum logic [1:0] {
        OFF_CONSOLE = 2'd0,
        OFF_HALT    = 2'd1,
        OFF_CYCLE   = 2'd2,
        OFF_SCRATCH = 2'd3
    } reg_off_e;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_COUNT_LO = 8;
    localparam int ST_COUNT_HI = 15;

    function automatic logic [31:0] console_status(
        input logic [7:0] count,
        input logic       ovf,
        input logic       full,
        input logic       empty
    );
        logic [31:0] w_s;
        w_s                          = '0;
        w_s[ST_COUNT_HI:ST_COUNT_LO] = count;
        w_s[ST_OVF]                  = ovf;
        w_s[ST_FULL]                 = full;
        w_s[ST_EMPTY]                = empty;
        return w_s;
    endfunction

endpackage

// File: rtl/mmio_test_responder_sync_fifo.sv
// Generic synchronous FIFO: data visible one cycle after push, no bypass.
// Push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_test_responder.sv
// MMIO test peripheral on the CPU data port: console FIFO, halt/exit code, cycle counter, scratch.
// Loads are combinational in the access cycle; stores land at the closing posedge.
module mmio_test_responder
    import mmio_test_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        sel,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        halted,
    output logic [31:0] exit_code
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_off_e    w_off;
    logic        w_acc;
    logic        w_wr;
    logic        w_con_push;
    logic        w_halt_wr;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [7:0]  w_fifo_rdata;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    logic        r_overflow;
    logic [31:0] r_cycle;
    logic [31:0] r_scratch;
    logic        r_halted;
    logic [31:0] r_exit_code;

    assign sel           = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off         = reg_off_e'(mem_addr[3:2]);
    assign w_acc         = sel && mem_en;
    assign w_wr          = w_acc && mem_we;
    assign w_con_push    = w_wr && (w_off == OFF_CONSOLE);
    assign w_halt_wr     = w_wr && (w_off == OFF_HALT);
    assign w_unused_addr = ^mem_addr[1:0];

    assign con_valid = !w_fifo_empty;
    assign con_data  = w_fifo_rdata;
    assign w_pop     = con_valid && con_ready;
    assign halted    = r_halted;
    assign exit_code = r_exit_code;
    assign mem_rdata = w_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_con_push),
        .i_wdata (mem_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_cycle     <= '0;
            r_scratch   <= '0;
            r_halted    <= 1'b0;
            r_exit_code <= '0;
        end else begin
            if (w_con_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            // The edge that latches halt must not advance the counter either.
            if (!r_halted && !w_halt_wr) r_cycle <= r_cycle + 1'b1;
            if (w_halt_wr && !r_halted) begin
                r_halted    <= 1'b1;
                r_exit_code <= mem_wdata;
            end
            if (w_wr && (w_off == OFF_SCRATCH)) r_scratch <= mem_wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_acc) begin
            case (w_off)
                OFF_CONSOLE: w_rdata = console_status(8'(w_fifo_count), r_overflow,
                                                      w_fifo_full, w_fifo_empty);
                OFF_HALT:    w_rdata = r_exit_code;
                OFF_CYCLE:   w_rdata = r_cycle;
                OFF_SCRATCH: w_rdata = r_scratch;
                default:     w_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_test_responder.sv
// Randomized bench for mmio_test_responder: behavioural model plus console-byte scoreboard.
module tb_mmio_test_responder;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        con_ready;
    wire         sel;
    wire  [31:0] mem_rdata;
    wire         con_valid;
    wire  [7:0]  con_data;
    wire         halted;
    wire  [31:0] exit_code;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  sb_q[$];
    int          m_cnt;
    bit          m_ovf;
    bit          m_halted;
    logic [31:0] m_cycle;
    logic [31:0] m_scratch;
    logic [31:0] m_exit;
    logic [31:0] last_rdata;

    mmio_test_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .sel       (sel),
        .mem_rdata (mem_rdata),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .halted    (halted),
        .exit_code (exit_code)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit in_window(input logic [31:0] addr);
        return (addr & 32'hFFFF_FFF0) == BASE;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int off;
        if (!in_window(addr)) return 32'h0;
        off = int'((addr - BASE) / 4) % 4;
        case (off)
            0: return 32'(m_cnt * 256 + (m_ovf ? 4 : 0) + ((m_cnt == DEPTH) ? 2 : 0) + ((m_cnt == 0) ? 1 : 0));
            1: return m_exit;
            2: return m_cycle;
            default: return m_scratch;
        endcase
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_ovf = 0; m_halted = 0;
        m_cycle = 0; m_scratch = 0; m_exit = 0;
        sb_q.delete();
    endtask

    // One bus cycle: drive just after a posedge, check mid-cycle, advance the model for the closing edge.
    task automatic step(input logic en, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rdy);
        bit win;
        bit pop;
        int off;
        mem_en = en; mem_we = we; mem_addr = addr; mem_wdata = wdata; con_ready = rdy;
        #3;
        win = in_window(addr);
        off = int'((addr - BASE) / 4) % 4;
        check("sel", sel, win);
        if (!we) check("rdata", mem_rdata, en ? model_read(addr) : 32'h0);
        last_rdata = mem_rdata;
        check("con_valid", con_valid, m_cnt > 0);
        check("halted", halted, m_halted);
        check("exit_code", exit_code, m_exit);

        pop = (m_cnt > 0) && rdy;
        if (en && we && win && off == 0) begin
            if (m_cnt < DEPTH || pop) begin
                sb_q.push_back(wdata[7:0]);
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_cnt--;
        if (en && we && win && off == 3) m_scratch = wdata;
        if (!m_halted && !(en && we && win && off == 1)) m_cycle = m_cycle + 1;
        if (en && we && win && off == 1 && !m_halted) begin
            m_halted = 1;
            m_exit   = wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; con_ready = 0;
        rst = 1;
        #1;
        check("rst_con_valid", con_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_exit_code", exit_code, 0);
        model_clear();
        #1 rst = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 0, 32'h0, 32'h0, 1);
    endtask

    // Scoreboard monitor: every accepted console byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && con_valid && con_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL con_unexpected: got byte 0x%02h with nothing expected at %0t", con_data, $time);
            end else begin
                check("con_data", con_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] n_cyc;
        mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; con_ready = 0;
        model_clear();
        rst = 1;
        #25 rst = 0;
        #1;
        check("reset_con_valid", con_valid, 0);
        check("reset_halted", halted, 0);
        check("reset_exit_code", exit_code, 0);

        step(1, 0, BASE + 8, 0, 0);
        check("cycle_first", last_rdata, 32'h0);

        // Two bytes held back, then drained back-to-back.
        step(1, 1, BASE, 32'h48, 0);
        step(1, 1, BASE, 32'h69, 0);
        step(1, 0, BASE, 0, 0);
        check("status_two", last_rdata, 32'h0000_0200);
        drain(3);

        // Full FIFO with a simultaneous pop and push.
        for (int i = 0; i < DEPTH; i++) step(1, 1, BASE, 32'h10 + i, 0);
        step(1, 1, BASE, 32'hA5, 1);
        step(1, 0, BASE, 0, 0);
        check("status_full_pushpop", last_rdata, 32'h0000_0802);
        drain(DEPTH + 2);

        // Nine stores into an eight-entry FIFO.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 1, BASE + 1, 32'h30 + i, 0);
        step(1, 0, BASE, 0, 0);
        check("status_overflow", last_rdata, 32'h0000_0806);
        drain(DEPTH + 2);

        step(1, 1, BASE + 12, 32'hDEAD_BEEF, 0);
        step(1, 0, BASE + 12, 0, 0);
        check("scratch", last_rdata, 32'hDEAD_BEEF);
        step(1, 0, BASE + 32'h10, 0, 0);
        check("outside_rdata", last_rdata, 32'h0);
        step(0, 0, BASE + 12, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic        we;
            int          off;
            if (i == 200) begin
                step(1, 1, BASE, 32'h77, 0);
                do_reset();
            end
            we  = ($urandom_range(0, 1) == 1);
            off = $urandom_range(0, 3);
            if (we && off == 1) off = 3;
            a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 9) < 7, we, a, $urandom(),
                 (i < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end
        drain(DEPTH + 2);

        // Halt: counter freezes, first exit code wins, console still drains.
        n_cyc = m_cycle;
        step(1, 1, BASE + 4, 32'd5, 0);
        step(1, 0, BASE + 8, 0, 0);
        check("cycle_frozen_a", last_rdata, n_cyc);
        step(0, 0, 0, 0, 0);
        step(1, 0, BASE + 8, 0, 0);
        check("cycle_frozen_b", last_rdata, n_cyc);
        step(1, 1, BASE + 4, 32'd7, 0);
        step(1, 0, BASE + 4, 0, 0);
        check("exit_first_wins", last_rdata, 32'd5);
        check("halted_set", halted, 1);
        step(1, 1, BASE, 32'h21, 0);
        step(1, 1, BASE, 32'h0A, 0);
        drain(4);
        step(1, 0, BASE + 8, 0, 0);
        check("cycle_frozen_c", last_rdata, n_cyc);

        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
